// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port; data wins ties.
// Define MEM_ARB_TIMEOUT_EN to abort transactions that see no bus_ack within TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        Fi_req,
  input  logic [31:0] Fi_addr,
  input  logic        Fi_flush,
  input  logic        Mi_memReq,
  input  logic        Mi_memWrite,
  input  logic [1:0]  Mi_memSize,
  input  logic [31:0] Mi_addr,
  input  logic [31:0] Mi_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_write,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [31:0] Fo_inst,
  output logic        Fo_valid,
  output logic        Fo_stall,
  output logic [31:0] Mo_rdata,
  output logic        Mo_valid,
  output logic        Mo_stall,
  output logic        o_busErr
);
  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_e;

  state_e      state_q;
  logic        own_data_q, discard_q;
  logic        bus_req_q, bus_write_q;
  logic [1:0]  bus_size_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [31:0] fo_inst_q, mo_rdata_q;
  logic        fo_valid_q, mo_valid_q;
  logic        busy, to_hit;
  logic        cmd_write_d;
  logic [1:0]  cmd_size_d;
  logic [31:0] cmd_addr_d, cmd_wdata_d;

  assign busy = (state_q == FETCH) || (state_q == DATA);

  // Command captured at grant; fetch is always a word read.
  always_comb begin
    cmd_write_d = 1'b0;
    cmd_size_d  = 2'b10;
    cmd_addr_d  = Fi_addr;
    cmd_wdata_d = 32'h0;
    if (Mi_memReq) begin
      cmd_write_d = Mi_memWrite;
      cmd_size_d  = Mi_memSize;
      cmd_addr_d  = Mi_addr;
      cmd_wdata_d = Mi_wdata;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt_q;
  logic        bus_err_q;

  assign to_hit = busy && !bus_ack && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge reset_x) begin
    if (reset_x) begin
      to_cnt_q  <= 16'h0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= to_hit;
      if (!busy)              to_cnt_q <= 16'h0;
      else if (!bus_ack)      to_cnt_q <= to_cnt_q + 16'h1;
    end
  end

  assign o_busErr = bus_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign to_hit   = 1'b0;
  assign o_busErr = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset_x) begin
    if (reset_x) begin
      state_q     <= IDLE;
      own_data_q  <= 1'b0;
      discard_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_write_q <= 1'b0;
      bus_size_q  <= 2'b00;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      fo_inst_q   <= 32'h0;
      mo_rdata_q  <= 32'h0;
      fo_valid_q  <= 1'b0;
      mo_valid_q  <= 1'b0;
    end else begin
      fo_valid_q <= 1'b0;
      mo_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          discard_q <= 1'b0;
          if (Mi_memReq || Fi_req) begin
            state_q     <= Mi_memReq ? DATA : FETCH;
            own_data_q  <= Mi_memReq;
            bus_req_q   <= 1'b1;
            bus_write_q <= cmd_write_d;
            bus_size_q  <= cmd_size_d;
            bus_addr_q  <= cmd_addr_d;
            bus_wdata_q <= cmd_wdata_d;
          end
        end
        FETCH, DATA: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            state_q   <= DONE;
            if (own_data_q) begin
              mo_rdata_q <= bus_rdata;
              mo_valid_q <= 1'b1;
            end else begin
              fo_inst_q  <= bus_rdata;
              fo_valid_q <= !(discard_q || Fi_flush);
            end
          end else if (to_hit) begin
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
            discard_q <= 1'b0;
          end else if (!own_data_q && Fi_flush) begin
            discard_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          discard_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_write = bus_write_q;
  assign bus_size  = bus_size_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign Fo_inst   = fo_inst_q;
  assign Mo_rdata  = mo_rdata_q;
  // A flush landing in the DONE cycle still kills the fetch result.
  assign Fo_valid  = fo_valid_q && !Fi_flush;
  assign Mo_valid  = mo_valid_q;
  assign Fo_stall  = Fi_req && !Fo_valid;
  assign Mo_stall  = Mi_memReq && !Mo_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected bus commands and results are queued
// by the stimulus and consumed by an independent negedge monitor.
module tb_mem_port_arbiter;
  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;
  typedef struct {
    logic        is_data;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_x = 1'b1;
  logic        Fi_req = 1'b0, Fi_flush = 1'b0;
  logic [31:0] Fi_addr = 32'h0;
  logic        Mi_memReq = 1'b0, Mi_memWrite = 1'b0;
  logic [1:0]  Mi_memSize = 2'b00;
  logic [31:0] Mi_addr = 32'h0, Mi_wdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_req, bus_write, Fo_valid, Fo_stall, Mo_valid, Mo_stall, o_busErr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, Fo_inst, Mo_rdata;

  int checks = 0;
  int errors = 0;
  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_x(reset_x),
    .Fi_req(Fi_req), .Fi_addr(Fi_addr), .Fi_flush(Fi_flush),
    .Mi_memReq(Mi_memReq), .Mi_memWrite(Mi_memWrite), .Mi_memSize(Mi_memSize),
    .Mi_addr(Mi_addr), .Mi_wdata(Mi_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_req(bus_req), .bus_write(bus_write), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .Fo_inst(Fo_inst), .Fo_valid(Fo_valid), .Fo_stall(Fo_stall),
    .Mo_rdata(Mo_rdata), .Mo_valid(Mo_valid), .Mo_stall(Mo_stall),
    .o_busErr(o_busErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare each new bus command and each result pulse against the queues.
  initial begin
    logic prev_req;
    cmd_t c;
    rsp_t r;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_x) begin
        if (bus_req && !prev_req) begin
          if (exp_cmd.size() == 0) check("unexpected bus command", 32'd1, 32'd0);
          else begin
            c = exp_cmd.pop_front();
            check("cmd write", {31'd0, bus_write}, {31'd0, c.write});
            check("cmd size",  {30'd0, bus_size},  {30'd0, c.size});
            check("cmd addr",  bus_addr,  c.addr);
            check("cmd wdata", bus_wdata, c.wdata);
          end
        end
        if (Fo_valid || Mo_valid) begin
          if (exp_rsp.size() == 0) check("unexpected valid pulse", {30'd0, Fo_valid, Mo_valid}, 32'd0);
          else begin
            r = exp_rsp.pop_front();
            check("rsp owner", {30'd0, Fo_valid, Mo_valid}, r.is_data ? 32'd1 : 32'd2);
            check("rsp data", r.is_data ? Mo_rdata : Fo_inst, r.data);
          end
        end
      end
      prev_req = bus_req;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_cmd(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.write = w; c.size = s; c.addr = a; c.wdata = d;
    exp_cmd.push_back(c);
  endtask

  task automatic push_rsp(input logic is_data, input logic [31:0] d);
    rsp_t r;
    r.is_data = is_data; r.data = d;
    exp_rsp.push_back(r);
  endtask

  // Returns at the negedge of the first cycle with bus_req high; n = cycles waited.
  task automatic wait_busreq(input string name, output int n);
    n = 0;
    @(negedge clk);
    while (!bus_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, bus_req}, 32'd1);
  endtask

  // One-cycle ack n cycles after the current cycle; returns 1ns into the following cycle.
  task automatic ack_after(input int n, input logic [31:0] d);
    repeat (n) @(posedge clk);
    #1 bus_ack = 1'b1; bus_rdata = d;
    @(posedge clk);
    #1 bus_ack = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic is_data);
    int n = 0;
    @(negedge clk);
    while (!(is_data ? Mo_valid : Fo_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, is_data ? Mo_valid : Fo_valid}, 32'd1);
    @(posedge clk);
    #1;
    if (is_data) Mi_memReq = 1'b0; else Fi_req = 1'b0;
  endtask

  initial begin
    int n;
    logic held;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset bus_req", {31'd0, bus_req}, 32'd0);
    check("reset bus_addr", bus_addr, 32'h0);
    check("reset valids/err", {29'd0, Fo_valid, Mo_valid, o_busErr}, 32'd0);
    check("reset rdata", Fo_inst | Mo_rdata, 32'h0);
    @(posedge clk); #1 reset_x = 1'b0;
    @(posedge clk); #1;

    // Plain fetch, ack 3 cycles after bus_req
    Fi_addr = 32'h100; Fi_req = 1'b1;
    push_cmd(1'b0, 2'b10, 32'h100, 32'h0);
    push_rsp(1'b0, 32'h00500093);
    wait_busreq("fetch bus_req", n);
    check("fetch grant latency", n, 32'd1);
    check("fetch stall while busy", {31'd0, Fo_stall}, 32'd1);
    ack_after(3, 32'h00500093);
    @(negedge clk);
    check("fetch valid after ack", {31'd0, Fo_valid}, 32'd1);
    check("fetch stall drops on valid", {31'd0, Fo_stall}, 32'd0);
    check("bus_req low in DONE", {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1 Fi_req = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests: store first, fetch granted 2 cycles after data ack
    Fi_addr = 32'h200; Fi_req = 1'b1;
    Mi_memReq = 1'b1; Mi_memWrite = 1'b1; Mi_memSize = 2'b10;
    Mi_addr = 32'h2000; Mi_wdata = 32'hDEADBEEF;
    push_cmd(1'b1, 2'b10, 32'h2000, 32'hDEADBEEF);
    push_cmd(1'b0, 2'b10, 32'h200, 32'h0);
    push_rsp(1'b1, 32'hCAFE0001);
    push_rsp(1'b0, 32'h0BADF00D);
    wait_busreq("store bus_req", n);
    check("store bus_write", {31'd0, bus_write}, 32'd1);
    ack_after(1, 32'hCAFE0001);
    @(negedge clk);
    check("store valid", {31'd0, Mo_valid}, 32'd1);
    check("fetch still stalled", {31'd0, Fo_stall}, 32'd1);
    @(posedge clk); #1 Mi_memReq = 1'b0;
    @(negedge clk);
    check("no bus_req in IDLE after DONE", {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    check("fetch issued after store", {31'd0, bus_req}, 32'd1);
    ack_after(1, 32'h0BADF00D);
    wait_valid("fetch after store valid", 1'b0);

    // Load with a flush pulse (ignored for data), then a stray ack in IDLE
    Mi_memReq = 1'b1; Mi_memWrite = 1'b0; Mi_memSize = 2'b00;
    Mi_addr = 32'h40; Mi_wdata = 32'h11111111;
    push_cmd(1'b0, 2'b00, 32'h40, 32'h11111111);
    push_rsp(1'b1, 32'h000000AB);
    wait_busreq("load bus_req", n);
    @(posedge clk); #1 Fi_flush = 1'b1;
    @(posedge clk); #1 Fi_flush = 1'b0;
    ack_after(0, 32'h000000AB);
    wait_valid("load valid despite flush", 1'b1);
    repeat (2) @(posedge clk);
    #1 bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1 bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("stray ack Mo_rdata held", Mo_rdata, 32'h000000AB);
    check("stray ack Fo_inst held", Fo_inst, 32'h0BADF00D);
    check("stray ack no bus_req", {31'd0, bus_req}, 32'd0);

    // Flush while fetch in flight: no Fo_valid
    @(posedge clk); #1 Fi_addr = 32'h300; Fi_req = 1'b1;
    push_cmd(1'b0, 2'b10, 32'h300, 32'h0);
    wait_busreq("flushed fetch bus_req", n);
    @(posedge clk); #1 Fi_flush = 1'b1; Fi_req = 1'b0;
    @(posedge clk); #1 Fi_flush = 1'b0;
    check("bus held through flush", {31'd0, bus_req}, 32'd1);
    ack_after(1, 32'h12345678);
    @(negedge clk);
    check("flushed fetch no valid", {31'd0, Fo_valid}, 32'd0);
    repeat (2) @(posedge clk); #1;

    // Next fetch proceeds normally
    Fi_addr = 32'h304; Fi_req = 1'b1;
    push_cmd(1'b0, 2'b10, 32'h304, 32'h0);
    push_rsp(1'b0, 32'h00A00113);
    wait_busreq("post-flush fetch bus_req", n);
    ack_after(2, 32'h00A00113);
    wait_valid("post-flush fetch valid", 1'b0);

    // Flush arriving in the DONE cycle
    @(posedge clk); #1 Fi_addr = 32'h308; Fi_req = 1'b1;
    push_cmd(1'b0, 2'b10, 32'h308, 32'h0);
    wait_busreq("done-flush fetch bus_req", n);
    ack_after(1, 32'h77777777);
    Fi_flush = 1'b1; Fi_req = 1'b0;
    @(negedge clk);
    check("flush in DONE suppresses valid", {31'd0, Fo_valid}, 32'd0);
    @(posedge clk); #1 Fi_flush = 1'b0;
    @(posedge clk); #1;

    // Reset mid-DATA, stray ack two cycles later
    Mi_memReq = 1'b1; Mi_memWrite = 1'b1; Mi_memSize = 2'b01;
    Mi_addr = 32'h3000; Mi_wdata = 32'h00000055;
    push_cmd(1'b1, 2'b01, 32'h3000, 32'h00000055);
    wait_busreq("pre-reset store bus_req", n);
    @(posedge clk); #1 reset_x = 1'b1; Mi_memReq = 1'b0;
    #1;
    check("async reset bus cmd", {bus_req, bus_write, bus_size} | bus_addr | bus_wdata, 32'h0);
    check("async reset data", Fo_inst | Mo_rdata, 32'h0);
    check("async reset pulses", {29'd0, Fo_valid, Mo_valid, o_busErr}, 32'd0);
    @(posedge clk); #1 reset_x = 1'b0;
    @(posedge clk); #1 bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
    @(posedge clk); #1 bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("post-reset stray ack ignored", Mo_rdata, 32'h0);
    check("post-reset idle", {31'd0, bus_req}, 32'd0);

    // No ack: timeout abort when enabled, otherwise wait indefinitely
    @(posedge clk); #1 Fi_addr = 32'h400; Fi_req = 1'b1;
    push_cmd(1'b0, 2'b10, 32'h400, 32'h0);
`ifdef MEM_ARB_TIMEOUT_EN
    push_cmd(1'b0, 2'b10, 32'h400, 32'h0);
    wait_busreq("timeout fetch bus_req", n);
    held = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!bus_req) held = 1'b0;
    end
    check("bus_req held 4 busy cycles", {31'd0, held}, 32'd1);
    @(negedge clk);
    check("timeout drop/err", {30'd0, bus_req, o_busErr}, 32'd1);
    @(negedge clk);
    check("timeout reissue", {30'd0, bus_req, o_busErr}, 32'd2);
`else
    wait_busreq("hang fetch bus_req", n);
    held = 1'b1;
    repeat (110) begin
      @(negedge clk);
      if (!bus_req || o_busErr) held = 1'b0;
    end
    check("bus_req held 110 cycles", {31'd0, held}, 32'd1);
`endif
    push_rsp(1'b0, 32'h00000013);
    ack_after(1, 32'h00000013);
    wait_valid("late fetch valid", 1'b0);

    repeat (3) @(negedge clk);
    check("cmd queue drained", exp_cmd.size(), 32'd0);
    check("rsp queue drained", exp_rsp.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 64, bus cycles allowed per granted transaction before abort (used only with MEM_ARB_TIMEOUT_EN; range 1..65535).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_x  in  1  reset, asynchronous and active-high.
REQ-004 Fi_req  in  1  fetch request; held high until Fo_valid.
REQ-005 Fi_addr  in  32  fetch address; stable while Fi_req high.
REQ-006 Fi_flush  in  1  pipeline flush; cancels the fetch result.
REQ-007 Mi_memReq  in  1  data request; held high until Mo_valid.
REQ-008 Mi_memWrite  in  1  1 = store, 0 = load.
REQ-009 Mi_memSize  in  2  access size code, passed through unchanged.
REQ-010 Mi_addr, Mi_wdata  in  32 each  data address and store data.
REQ-011 bus_ack  in  1  memory completion strobe, 1 cycle.
REQ-012 bus_rdata  in  32  read data; valid with bus_ack.
REQ-013 bus_req, bus_write  out  1 each  memory port request and write enable.
REQ-014 bus_size  out  2; bus_addr, bus_wdata  out  32 each  memory port command fields.
REQ-015 Fo_inst  out  32, Fo_valid  out  1, Fo_stall  out  1  fetch data, result pulse, and fetch stall.
REQ-016 Mo_rdata  out  32, Mo_valid  out  1, Mo_stall  out  1  data read value, result pulse, and data stall.
REQ-017 o_busErr  out  1  timeout abort pulse.

Function
REQ-018 States: IDLE, FETCH, DATA, DONE. DONE carries an owner flag (fetch/data).
REQ-019 IDLE: if Mi_memReq -> DATA; else if Fi_req -> FETCH; else stay. Data SHALL win simultaneous requests.
REQ-020 On grant, the bus command (req, write, size, addr, wdata; write=0 and wdata=0 for fetch, size=2'b10 for fetch) SHALL be registered, so bus_req rises 1 cycle after the IDLE grant cycle.
REQ-021 All bus outputs SHALL be held stable from grant until the bus_ack cycle. No switching while busy.
REQ-022 FETCH/DATA with bus_ack: capture bus_rdata into Fo_inst or Mo_rdata, deassert bus_req next edge, go DONE.
REQ-023 DONE lasts exactly 1 cycle and pulses the owner's valid; then IDLE. No grant is made in DONE.
REQ-024 Latency: request seen in IDLE at cycle t; bus_req at t+1; ack at t+k; valid at t+k+1; earliest next grant at t+k+2.
REQ-025 Fo_stall = Fi_req & ~Fo_valid; Mo_stall = Mi_memReq & ~Mo_valid (combinational).
REQ-026 Fi_flush in FETCH SHALL set a discard flag. The transaction still completes on the bus, and Fo_valid is suppressed in DONE. Fi_flush during DONE(fetch) also suppresses Fo_valid. The flag clears on entry to IDLE.
REQ-027 Fi_flush SHALL NOT affect data transactions.
REQ-028 bus_ack in IDLE or DONE SHALL be ignored.
REQ-029 Fo_inst and Mo_rdata SHALL hold their last captured value until the next capture.

Reset
REQ-030 reset_x high SHALL immediately force IDLE with these outputs at 0: bus_req, bus_write, bus_size, bus_addr, bus_wdata, Fo_inst, Fo_valid, Mo_rdata, Mo_valid, o_busErr. The discard flag and timeout counter SHALL also clear.
REQ-031 Reset during an outstanding transaction abandons it. A later stray bus_ack is ignored per REQ-028.

Configuration
REQ-032 Macro MEM_ARB_TIMEOUT_EN, when defined: a 16-bit counter clears on grant and increments each FETCH/DATA cycle without bus_ack.
REQ-033 On reaching TIMEOUT, the block SHALL drop bus_req, pulse o_busErr for 1 cycle, and return to IDLE without a valid pulse. The still-pending request is re-arbitrated.
REQ-034 When MEM_ARB_TIMEOUT_EN is undefined: no counter; the block waits indefinitely for bus_ack; o_busErr is tied to 0.

Verification
REQ-035 Fi_req=1, Fi_addr=0x100, ack 3 cycles after bus_req, bus_rdata=0x00500093 -> bus_addr=0x100, bus_write=0; Fo_valid 1 cycle after ack with Fo_inst=0x00500093; Fo_stall high until then.
REQ-036 Fi_req and Mi_memReq (store, addr 0x2000, wdata 0xDEADBEEF, size 2'b10) rise the same cycle -> data granted first, bus_write=1; fetch issues 2 cycles after the data ack.
REQ-037 Fetch in flight, Fi_flush pulses 1 cycle, ack with 0x12345678 -> Fo_valid stays 0; the next fetch proceeds normally.
REQ-038 reset_x pulsed mid-DATA, bus_ack arrives 2 cycles later -> all outputs 0, state IDLE, no Mo_valid.
REQ-039 MEM_ARB_TIMEOUT_EN defined, TIMEOUT=4, no ack -> bus_req drops after 4 busy cycles, o_busErr 1-cycle pulse, request re-issued 2 cycles later. With the macro undefined, bus_req stays high for 100+ cycles.
